// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word width, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder; returns the first set
// request bit found searching upward from (last_i + 1) mod NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            valid_o,
  output logic [IW-1:0]   index_o
);

  int idx;

  // Walk the search order backwards so the nearest candidate is written last.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_i) + k) % NREQ;
      if (req_i[IW'(idx)]) begin
        valid_o = 1'b1;
        index_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ word requesters.
// Optional per-grant BUSY timeout is built when ARB_TIMEOUT_EN is defined.
module ram_port_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ-1:0][31:0]    req_addr,
  input  logic [NREQ-1:0][31:0]    req_store,
  output logic [NREQ-1:0]          req_wait,
  output logic [NREQ-1:0][31:0]    req_load,
  input  ramstate_t                ramstate,
  input  word_t                    ramload,
  output word_t                    ramaddr,
  output word_t                    ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     arb_err
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_param_chk
    $error("ram_port_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
  end

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] active;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            own_act;
  logic            own_wr;
  logic            tmo_hit;

  assign active  = req_ren | req_wen;
  assign own_act = active[owner_q];
  assign own_wr  = req_wen[owner_q];

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (active),
    .last_i  (last_q),
    .valid_o (pick_vld),
    .index_o (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Zero throughout IDLE, so the first GRANT cycle always sees a count of 0.
  assign tmo_d   = (state_q == GRANT) ? tmo_q + TW'(1) : '0;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    req_wait = active;
    req_load = '0;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    grant_id = '0;
    arb_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        grant_id = owner_q;
        if (!own_act) begin
          // Owner abandoned: release the port without advancing priority.
          state_d = IDLE;
        end else begin
          ramaddr = req_addr[owner_q];
          if (own_wr) begin
            ramWEN   = 1'b1;
            ramstore = req_store[owner_q];
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == ACCESS) begin
            req_wait[owner_q] = 1'b0;
            if (!own_wr) req_load[owner_q] = ramload;
            last_d  = owner_q;
            state_d = IDLE;
          end else if (ramstate == ERROR || tmo_hit) begin
            arb_err = 1'b1;
            last_d  = owner_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (RST) req_wait = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic, every
// cycle's outputs predicted by a transaction-level model and checked by a monitor.
module tb_ram_port_arbiter;
  import cpu_types_pkg::*;

  localparam int N   = 2;
  localparam int IW  = $clog2(N);
  localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [N-1:0]        req_ren = '0, req_wen = '0, req_wait;
  logic [N-1:0][31:0]  req_addr = '0, req_store = '0, req_load;
  ramstate_t           ramstate = FREE;
  word_t               ramload = '0, ramaddr, ramstore;
  logic                ramREN, ramWEN, arb_err;
  logic [IW-1:0]       grant_id;

  always #5 CLK = ~CLK;

  ram_port_arbiter #(.NREQ(N), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ramstate(ramstate), .ramload(ramload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .grant_id(grant_id), .arb_err(arb_err)
  );

  typedef struct packed {
    logic [N-1:0]       w;
    logic [N-1:0][31:0] ld;
    logic [31:0]        a;
    logic [31:0]        s;
    logic               r;
    logic               wr;
    logic               e;
    logic [IW-1:0]      g;
  } snap_t;

  snap_t  expq[$];
  snap_t  act_s, exp_s;
  int     n_tests = 0;
  int     n_fail  = 0;

  // Reference model: who holds the port (if anyone), who was served last.
  bit     m_busy = 1'b0;
  int     m_own  = 0;
  int     m_last = N - 1;
  int     m_cnt  = 0;
  logic [N-1:0] done_v = '0;

  task automatic eval();
    snap_t e;
    logic [N-1:0] act;
    bit found;
    int j;
    act    = req_ren | req_wen;
    e      = '0;
    e.w    = act;
    done_v = '0;
    if (RST) begin
      e.w    = '0;
      m_busy = 1'b0;
      m_own  = 0;
      m_last = N - 1;
      m_cnt  = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && act[IW'(j)]) begin
          found = 1'b1;
          m_own = j;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      e.g = IW'(m_own);
      if (!act[IW'(m_own)]) begin
        m_busy = 1'b0;
      end else begin
        e.a = req_addr[IW'(m_own)];
        if (req_wen[IW'(m_own)]) begin
          e.wr = 1'b1;
          e.s  = req_store[IW'(m_own)];
        end else begin
          e.r = 1'b1;
        end
        if (ramstate == ACCESS) begin
          e.w[IW'(m_own)] = 1'b0;
          if (!req_wen[IW'(m_own)]) e.ld[IW'(m_own)] = ramload;
          done_v[IW'(m_own)] = 1'b1;
          m_last = m_own;
          m_busy = 1'b0;
        end else if (ramstate == ERROR || (TMO_ON && m_cnt == TMO - 1)) begin
          e.e    = 1'b1;
          m_last = m_own;
          m_busy = 1'b0;
        end else begin
          m_cnt++;
        end
      end
    end
    expq.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (expq.size() != 0) begin
      exp_s    = expq.pop_front();
      act_s.w  = req_wait;
      act_s.ld = req_load;
      act_s.a  = ramaddr;
      act_s.s  = ramstore;
      act_s.r  = ramREN;
      act_s.wr = ramWEN;
      act_s.e  = arb_err;
      act_s.g  = grant_id;
      n_tests++;
      if (act_s !== exp_s) begin
        n_fail++;
        $display("FAIL snapshot t=%0t: got wait=%b gid=%0d ren=%b wen=%b addr=%h store=%h err=%b load=%h; want wait=%b gid=%0d ren=%b wen=%b addr=%h store=%h err=%b load=%h",
                 $time, act_s.w, act_s.g, act_s.r, act_s.wr, act_s.a, act_s.s, act_s.e, act_s.ld,
                 exp_s.w, exp_s.g, exp_s.r, exp_s.wr, exp_s.a, exp_s.s, exp_s.e, exp_s.ld);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    RST = 1'b1; req_ren = '0; req_wen = '0; ramstate = FREE;
    eval();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] pend, pr, pw;
  int op;

  initial begin
    // Reset state
    cyc();
    eval();
    @(negedge CLK);
    chk("reset_wait", 32'(req_wait), 32'h0);
    chk("reset_ren", 32'(ramREN), 32'h0);

    // Single read, zero-latency on second cycle
    cyc(); RST = 1'b0; req_ren = 2'b01; req_addr[0] = 32'h40; ramstate = FREE; eval();
    @(negedge CLK); chk("rd_wait_hold", 32'(req_wait[0]), 32'h1);
    cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF; eval();
    @(negedge CLK);
    chk("rd_gid", 32'(grant_id), 32'h0);
    chk("rd_wait_drop", 32'(req_wait[0]), 32'h0);
    chk("rd_load", req_load[0], 32'hDEADBEEF);
    chk("rd_addr", ramaddr, 32'h40);
    cyc(); req_ren = '0; eval();

    // Contention: grants alternate 0,1,0,1 with an idle cycle between
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc(); RST = 1'b0; req_ren = 2'b11; ramstate = ACCESS; ramload = 32'h100 + 32'(c); eval();
      @(negedge CLK);
      if (c % 2 == 1) chk("contend_gid", 32'(grant_id), 32'((c / 2) % 2));
      else            chk("contend_gap", 32'(ramREN), 32'h0);
    end
    cyc(); req_ren = '0; eval();

    // Write wins when both strobes set
    do_reset();
    cyc(); RST = 1'b0; req_ren = 2'b10; req_wen = 2'b10; req_addr[1] = 32'h80;
    req_store[1] = 32'h1234; ramstate = BUSY; eval();
    cyc(); eval();
    @(negedge CLK);
    chk("wr_wen", 32'(ramWEN), 32'h1);
    chk("wr_ren", 32'(ramREN), 32'h0);
    chk("wr_store", ramstore, 32'h1234);
    cyc(); ramstate = ACCESS; eval();
    @(negedge CLK); chk("wr_load_zero", req_load[1], 32'h0);
    cyc(); req_ren = '0; req_wen = '0; eval();

    // Abandon: owner 1 drops while BUSY; priority pointer stays at 0
    do_reset();
    cyc(); RST = 1'b0; req_ren = 2'b01; ramstate = FREE; eval();
    cyc(); ramstate = ACCESS; eval();
    cyc(); req_ren = 2'b10; ramstate = BUSY; eval();
    cyc(); eval();
    cyc(); req_ren = 2'b00; eval();
    @(negedge CLK);
    chk("abandon_ren", 32'(ramREN), 32'h0);
    chk("abandon_wait", 32'(req_wait), 32'h0);
    cyc(); req_ren = 2'b11; eval();
    @(negedge CLK); chk("abandon_idle", 32'(ramREN), 32'h0);
    cyc(); eval();
    @(negedge CLK); chk("abandon_next_gid", 32'(grant_id), 32'h1);
    cyc(); req_ren = '0; eval();

    // RAM error: pulse, wait held, requester 0 retried after requester 1
    do_reset();
    cyc(); RST = 1'b0; req_ren = 2'b11; ramstate = FREE; eval();
    cyc(); ramstate = ERROR; eval();
    @(negedge CLK);
    chk("err_pulse", 32'(arb_err), 32'h1);
    chk("err_wait", 32'(req_wait[0]), 32'h1);
    cyc(); ramstate = FREE; eval();
    @(negedge CLK); chk("err_one_cycle", 32'(arb_err), 32'h0);
    cyc(); ramstate = ACCESS; eval();
    @(negedge CLK); chk("err_other_gid", 32'(grant_id), 32'h1);
    cyc(); eval();
    cyc(); eval();
    @(negedge CLK); chk("err_retry_gid", 32'(grant_id), 32'h0);
    cyc(); req_ren = '0; eval();

`ifdef ARB_TIMEOUT_EN
    // Timeout abort on the TMO-th BUSY grant cycle
    do_reset();
    cyc(); RST = 1'b0; req_ren = 2'b01; ramstate = BUSY; eval();
    for (int c = 1; c <= TMO; c++) begin
      cyc(); eval();
      @(negedge CLK); chk("tmo_err", 32'(arb_err), (c == TMO) ? 32'h1 : 32'h0);
    end
    cyc(); eval();
    @(negedge CLK); chk("tmo_strobe_low", 32'(ramREN), 32'h0);
    cyc(); req_ren = '0; eval();
`endif

    // Asynchronous reset in the middle of a grant
    do_reset();
    cyc(); RST = 1'b0; req_ren = 2'b01; ramstate = BUSY; eval();
    cyc(); eval();
    @(negedge CLK); chk("mid_grant_ren", 32'(ramREN), 32'h1);
    cyc(); RST = 1'b1; eval();
    @(negedge CLK);
    chk("async_rst_ren", 32'(ramREN), 32'h0);
    chk("async_rst_wait", 32'(req_wait), 32'h0);
    chk("async_rst_addr", ramaddr, 32'h0);
    cyc(); RST = 1'b0; req_ren = '0; eval();

    // Randomized traffic
    pend = '0; pr = '0; pw = '0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (done_v[IW'(i)]) pend[IW'(i)] = 1'b0;
        if (pend[IW'(i)] && m_busy && m_own == i && $urandom_range(15) == 0) begin
          pend[IW'(i)] = 1'b0;
        end else if (!pend[IW'(i)] && $urandom_range(1) == 0) begin
          pend[IW'(i)] = 1'b1;
          op = int'($urandom_range(2));
          pr[IW'(i)] = (op != 1);
          pw[IW'(i)] = (op != 0);
          req_addr[IW'(i)]  = $urandom;
          req_store[IW'(i)] = $urandom;
        end
      end
      req_ren = pend & pr;
      req_wen = pend & pw;
      case ($urandom_range(9))
        0, 1, 2, 3: ramstate = ACCESS;
        4, 5, 6:    ramstate = BUSY;
        7, 8:       ramstate = FREE;
        default:    ramstate = ERROR;
      endcase
      ramload = $urandom;
      eval();
    end

    cyc(); req_ren = '0; req_wen = '0; eval();
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
